bfp_unpack: RTL and testbench
=============================

# bfp_unpack

Block-floating-point unpacker for the FFT datapath. It takes 64-element blocks that share one exponent, the format produced by the shared-max-exponent search. It re-normalises each element into a per-element exponent plus a left-justified sign-magnitude mantissa. The block is streaming (LANES elements per beat) and uses a 2-stage valid/ready pipeline. It sits on the FFT output side, ahead of per-element float consumers.

## Interface
- expWidth, 4, width of shared and per-element exponent (unsigned)
- manWidth, 8, mantissa width: bit manWidth-1 = sign, remaining bits = magnitude
- LANES, 4, elements per beat; 64/LANES beats per block (16 at default)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_exp  in  expWidth  shared block exponent; sampled only on beat 0 of a block
- in_man  in  LANES*manWidth  element mantissas; lane k at bits [(k+1)*manWidth-1 : k*manWidth]
- in_last  in  1  asserted by source on final beat of block
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_exp  out  LANES*expWidth  per-element exponents, same lane packing
- out_man  out  LANES*manWidth  normalised sign-magnitude mantissas
- out_last  out  1  final beat of block (internal beat count == 64/LANES-1)
- blk_err  out  1  one-cycle pulse on framing error

## Operation
- Beat counter `beat` runs 0..64/LANES-1 and increments on each accepted input beat. It wraps to 0 after the last beat.
- On an accepted beat with beat==0, in_exp is latched into `shexp`. The shared exponent used for each beat travels with that beat through the pipeline. A new block's exponent therefore never corrupts in-flight beats of the previous block.
- Stage 1 registers the beat and computes per-lane lzc, the count of leading zeros in the (manWidth-1)-bit magnitude.
- Stage 2, per lane, with mag = magnitude and e = shexp:
  - mag==0: exp=0, man=0 (sign cleared).
  - lzc<=e: man magnitude = mag<<lzc (MSB set), exp = e-lzc.
  - lzc>e: denormal; magnitude = mag<<e, exp=0.
  - The sign bit always passes through unchanged, except in the zero case.
- Framing check on every accepted beat:
  - in_last && beat!=last: blk_err pulse, beat forced to 0 for next beat.
  - !in_last && beat==last: blk_err pulse, beat wraps to 0 normally.
  - Data is still processed in both cases. out_last follows the internal counter, not in_last.
- No arithmetic overflow is possible: exp only decreases, and the shift is bounded by lzc.

## Timing
- Latency: accepted input beat appears on out_* exactly 2 cycles later when out_ready is held high. Throughput is 1 beat/cycle.
- Handshake rules:
  - in_ready = !s1_v || !s2_v || out_ready.
  - Stage 2 loads when !s2_v || out_ready.
  - Stage 1 loads when in_ready.
- out_* must hold stable while out_valid && !out_ready.
- Simultaneous events: an accept on beat 0 and an output of the previous block's last beat in the same cycle is legal and requires no bubble.
- Reset (asserted asynchronously, including mid-block):
  - out_valid=0, out_exp=0, out_man=0, out_last=0, blk_err=0.
  - beat=0, shexp=0, stage valids=0.
  - in_ready=1 in the first cycle after deassertion.
  - A partial block is discarded; the next accepted beat is beat 0.

## Structure
- Shared package `bfp_pkg`: default expWidth/manWidth/LANES, BEATS=64/LANES, beat counter width, and lane slice helper constants.
- One sub-module `lzc_norm`, instantiated LANES times. It is purely combinational and takes mag and e, producing normalised magnitude and exponent.
- Top level holds the beat counter, shexp, framing check and the two pipeline registers.

## Test plan
- Single block, out_ready=1, shared exp 9, all lanes magnitude 0x10, sign 0 -> 16 output beats, every lane out_man=0x40, out_exp=7, out_last on beat 15 only, latency 2.
- Denormal and zero: shared exp 1, lanes {0x04, 0x00, 0x7F, 0x84} -> {man 0x08/exp 0, man 0x00/exp 0, man 0x7F/exp 1, man 0x88/exp 0}.
- Back-pressure: random out_ready at 50% over 4 back-to-back blocks with exps 3, 15, 0, 8 -> no beat lost or duplicated, outputs stable while stalled, each block uses its own exponent.
- Framing: in_last on beat 9 -> blk_err pulses once, next beat treated as beat 0 and relatches in_exp. Missing in_last on beat 15 -> blk_err pulse, out_last still on beat 15.
- Reset mid-block after 7 beats with both stages full -> all outputs 0 immediately. A fresh block afterwards produces correct results from beat 0.

Source files
------------

// File: rtl/bfp_pkg.sv
// bfp_pkg: shared defaults and lane helpers for the block-floating-point unpacker
package bfp_pkg;
  localparam int DEF_EXP_W = 4;
  localparam int DEF_MAN_W = 8;
  localparam int DEF_LANES = 4;
  localparam int BLOCK_LEN = 64;
  localparam int BEATS = BLOCK_LEN / DEF_LANES;
  localparam int BEAT_W = $clog2(BEATS);
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/lzc_norm.sv
// lzc_norm: renormalise one sign-magnitude mantissa against a shared exponent
module lzc_norm #(
  parameter int EW = 4,
  parameter int MW = 8,
  parameter int LW = $clog2(MW)
) (
  input  logic [MW-1:0] man,
  input  logic [LW-1:0] lzc,
  input  logic [EW-1:0] e,
  output logic [MW-1:0] nman,
  output logic [EW-1:0] nexp
);
  logic [MW-2:0] mag;
  logic [EW-1:0] sh;
  logic zero;
  always_comb begin
    mag = man[MW-2:0];
    zero = mag == '0;
    // shift is capped by the exponent so it can never underflow
    sh = (int'(lzc) <= int'(e)) ? EW'(lzc) : e;
    nman = zero ? '0 : {man[MW-1], mag << sh};
    nexp = zero ? '0 : e - sh;
  end
endmodule

// File: rtl/bfp_unpack.sv
// bfp_unpack: streaming shared-exponent block to per-element exponent unpacker
module bfp_unpack
  import bfp_pkg::*;
#(
  parameter int expWidth = DEF_EXP_W,
  parameter int manWidth = DEF_MAN_W,
  parameter int LANES = DEF_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [expWidth-1:0]          in_exp,
  input  logic [LANES*manWidth-1:0]    in_man,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*expWidth-1:0]    out_exp,
  output logic [LANES*manWidth-1:0]    out_man,
  output logic                         out_last,
  output logic                         blk_err
);
  localparam int NB = BLOCK_LEN / LANES;
  localparam int BW = $clog2(NB);
  localparam int MG = manWidth - 1;
  localparam int LW = $clog2(manWidth);
  logic [BW-1:0] beat;
  logic [expWidth-1:0] shexp, beat_exp;
  logic s1_v, s1_last, s2_v, acc, s2_ld, is_last, first;
  logic [expWidth-1:0] s1_exp;
  logic [LANES*manWidth-1:0] s1_man, n_man;
  logic [LANES*LW-1:0] lzc, s1_lzc;
  logic [LANES*expWidth-1:0] n_exp;
  assign in_ready = !s1_v || !s2_v || out_ready;
  assign out_valid = s2_v;
  assign acc = in_valid && in_ready;
  assign s2_ld = !s2_v || out_ready;
  assign is_last = beat == BW'(NB - 1);
  assign first = beat == '0;
  // beat 0 carries its exponent straight from the input while shexp is being latched
  assign beat_exp = first ? in_exp : shexp;
  always_comb begin
    lzc = '0;
    for (int k = 0; k < LANES; k++) begin
      lzc[k*LW +: LW] = LW'(MG);
      for (int i = 0; i < MG; i++)
        if (in_man[lane_lo(k, manWidth) + i]) lzc[k*LW +: LW] = LW'(MG - 1 - i);
    end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lzc_norm #(.EW(expWidth), .MW(manWidth), .LW(LW)) u_norm (
      .man (s1_man[k*manWidth +: manWidth]),
      .lzc (s1_lzc[k*LW +: LW]),
      .e   (s1_exp),
      .nman(n_man[k*manWidth +: manWidth]),
      .nexp(n_exp[k*expWidth +: expWidth])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
      shexp <= '0;
      blk_err <= 1'b0;
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      s1_exp <= '0;
      s1_man <= '0;
      s1_lzc <= '0;
      s2_v <= 1'b0;
      out_exp <= '0;
      out_man <= '0;
      out_last <= 1'b0;
    end else begin
      blk_err <= acc && (in_last != is_last);
      if (acc) begin
        beat <= (in_last || is_last) ? '0 : beat + 1'b1;
        if (first) shexp <= in_exp;
      end
      if (in_ready) begin
        s1_v <= in_valid;
        s1_last <= is_last;
        s1_exp <= beat_exp;
        s1_man <= in_man;
        s1_lzc <= lzc;
      end
      if (s2_ld) begin
        s2_v <= s1_v;
        out_exp <= n_exp;
        out_man <= n_man;
        out_last <= s1_v && s1_last;
      end
    end
  end
endmodule

// File: tb/tb_bfp_unpack.sv
// tb_bfp_unpack: randomized directed bench for bfp_unpack with a block-level reference model
module tb_bfp_unpack;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last, blk_err;
  logic [3:0] in_exp;
  logic [31:0] in_man, out_man;
  logic [15:0] out_exp;
  always #5 clk = ~clk;
  bfp_unpack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp),
    .in_man(in_man), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_man(out_man), .out_last(out_last), .blk_err(blk_err)
  );
  typedef struct {logic [15:0] e; logic [31:0] m; logic l; int c;} beat_t;
  beat_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0, mbeat = 0;
  logic [3:0] mexp = 0;
  logic err_next = 0, stall_prev = 0, bp = 0, lat_chk = 0, acc_f = 0;
  logic [48:0] held = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Reference: each element doubles its magnitude while the exponent allows and bit 6 is clear
  function automatic void model(input logic [3:0] e_in, input logic [31:0] man, input logic last);
    beat_t b;
    int mg, x;
    if (mbeat == 0) mexp = e_in;
    b.e = 0;
    b.m = 0;
    for (int k = 0; k < 4; k++) begin
      mg = int'(man[k*8 +: 7]);
      x = int'(mexp);
      if (mg == 0) continue;
      while (x > 0 && mg < 64) begin
        mg = mg * 2;
        x--;
      end
      b.m[k*8 +: 8] = {man[k*8+7], 7'(mg)};
      b.e[k*4 +: 4] = 4'(x);
    end
    b.l = mbeat == 15;
    b.c = cyc;
    err_next = last != (mbeat == 15);
    mbeat = (last || mbeat == 15) ? 0 : mbeat + 1;
    q.push_back(b);
  endfunction
  task automatic tick();
    beat_t b;
    if (bp) out_ready = 1'($urandom_range(0, 1));
    #1;
    cyc++;
    if (stall_prev) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_man", out_man, held[31:0]);
      chk("hold_exp_last", 32'({out_last, out_exp}), 32'(held[48:32]));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("extra_beat", 32'(out_valid), 0);
      else begin
        b = q.pop_front();
        chk("out_man", out_man, b.m);
        chk("out_exp", 32'(out_exp), 32'(b.e));
        chk("out_last", 32'(out_last), 32'(b.l));
        if (lat_chk) chk("latency", 32'(cyc - b.c), 2);
      end
    end
    chk("blk_err", 32'(blk_err), 32'(err_next));
    err_next = 0;
    stall_prev = out_valid && !out_ready;
    held = {out_last, out_exp, out_man};
    acc_f = in_valid && in_ready;
    if (acc_f) model(in_exp, in_man, in_last);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input logic [3:0] e, input logic [31:0] m, input logic last);
    in_valid = 1;
    in_exp = e;
    in_man = m;
    in_last = last;
    acc_f = 0;
    for (int i = 0; i < 50 && !acc_f; i++) tick();
    if (!acc_f) chk("accept_timeout", 32'(acc_f), 1);
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic blk(input logic [3:0] e, input int n, input int last_at, input logic [31:0] m0, input logic fix);
    for (int b = 0; b < n; b++) begin
      if (bp && $urandom_range(0, 3) == 0) tick();
      send(b == 0 ? e : 4'($urandom), fix ? m0 : $urandom, b == last_at);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) tick();
    chk("drain", 32'(q.size()), 0);
  endtask
  initial begin
    logic [3:0] exps[4] = '{4'd3, 4'd15, 4'd0, 4'd8};
    rst = 1;
    in_valid = 0;
    in_exp = 0;
    in_man = 0;
    in_last = 0;
    out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_man", out_man, 0);
    chk("rst_exp", 32'(out_exp), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_err", 32'(blk_err), 0);
    rst = 0;
    #1 chk("ready_after_rst", 32'(in_ready), 1);
    @(negedge clk);
    lat_chk = 1;
    blk(4'd9, 16, 15, 32'h10101010, 1);
    drain();
    lat_chk = 0;
    blk(4'd1, 16, 15, 32'h847F0004, 1);
    drain();
    bp = 1;
    for (int b = 0; b < 4; b++) blk(exps[b], 16, 15, 0, 0);
    drain();
    bp = 0;
    out_ready = 1;
    blk(4'd5, 10, 9, 0, 0);
    blk(4'd11, 16, -1, 0, 0);
    blk(4'd2, 16, 15, 0, 0);
    drain();
    blk(4'd6, 7, -1, 0, 0);
    #1 chk("full_before_rst", 32'(out_valid), 1);
    #1 rst = 1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_man", out_man, 0);
    chk("async_rst_exp", 32'(out_exp), 0);
    chk("async_rst_last", 32'(out_last), 0);
    chk("async_rst_err", 32'(blk_err), 0);
    @(negedge clk);
    rst = 0;
    q.delete();
    mbeat = 0;
    err_next = 0;
    stall_prev = 0;
    #1 chk("ready_after_mid_rst", 32'(in_ready), 1);
    blk(4'd13, 16, 15, 0, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
